// File: rtl/control_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// cpu_defs : shared definitions for the Mini SRC hardwired control unit.
//   - opcode field values (IR[31:27])
//   - ALU operation codes driven on ALU_op
//   - bus source codes driven on BusDataSelect
//   - sequencer state and instruction class encodings
// ----------------------------------------------------------------------------
package cpu_defs;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_LDI  = 5'b01000;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_ADD = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0101;
   localparam logic [3:0] ALU_OR  = 4'b0110;

   localparam logic [4:0] BUS_NONE   = 5'b00000;
   localparam logic [4:0] BUS_GP     = 5'b00001;
   localparam logic [4:0] BUS_HI     = 5'b10000;
   localparam logic [4:0] BUS_LO     = 5'b10001;
   localparam logic [4:0] BUS_ZLO    = 5'b10011;
   localparam logic [4:0] BUS_PC     = 5'b10100;
   localparam logic [4:0] BUS_MDR    = 5'b10101;
   localparam logic [4:0] BUS_INPORT = 5'b10110;
   localparam logic [4:0] BUS_C      = 5'b11000;

   typedef enum logic [3:0] {
      S_F0, S_F1, S_F2, S_F3,
      S_T3, S_T4, S_T5, S_T6, S_T7, S_T8,
      S_HALT
   } state_e;

   typedef enum logic [3:0] {
      CLS_ALU, CLS_ADDI, CLS_LDI, CLS_LD, CLS_ST, CLS_BR, CLS_JR, CLS_JAL,
      CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILLEGAL
   } class_e;

endpackage

// File: rtl/control_sequencer_if.sv
// ----------------------------------------------------------------------------
// control_sequencer_if : bundle between the control unit and the datapath.
//   IR, CON_FF            : datapath state read back by the control unit
//   e_* / incPC           : register load and strobe enables
//   ram_read/ram_write/MDR_read : memory controls
//   ALU_op, BusDataSelect : ALU operation and bus source select
//   Gra/Grb/Grc/e_Rin/e_Rout/BAout/imm_sel : register file select/encode
//   run, illegal          : status
// master = control unit side, slave = datapath side.
// ----------------------------------------------------------------------------
interface control_sequencer_if;
   logic [31:0] IR;
   logic        CON_FF;
   logic        incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_OutPort, e_RA, e_CON_FF;
   logic        ram_read, ram_write, MDR_read;
   logic [3:0]  ALU_op;
   logic [4:0]  BusDataSelect;
   logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
   logic        run, illegal;

   modport master (
      input  IR, CON_FF,
      output incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_OutPort, e_RA, e_CON_FF,
      output ram_read, ram_write, MDR_read, ALU_op, BusDataSelect,
      output Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, run, illegal
   );

   modport slave (
      output IR, CON_FF,
      input  incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_OutPort, e_RA, e_CON_FF,
      input  ram_read, ram_write, MDR_read, ALU_op, BusDataSelect,
      input  Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, run, illegal
   );
endinterface

// File: rtl/control_sequencer_opcode_class_decode.sv
// ----------------------------------------------------------------------------
// opcode_class_decode : combinational map of IR[31:27] to an instruction
// class and, for register-register ALU instructions, the ALU operation.
//   opcode   in  5  IR[31:27]
//   op_class out    instruction class (CLS_ILLEGAL for undefined opcodes)
//   alu_op   out 4  ALU operation for CLS_ALU (ALU_ADD otherwise)
// ----------------------------------------------------------------------------
module opcode_class_decode
   import cpu_defs::*;
(
   input  logic [4:0] opcode,
   output class_e     op_class,
   output logic [3:0] alu_op
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      alu_op   = ALU_ADD;
      case (opcode)
         OP_ADD:  begin op_class = CLS_ALU; alu_op = ALU_ADD; end
         OP_SUB:  begin op_class = CLS_ALU; alu_op = ALU_SUB; end
         OP_AND:  begin op_class = CLS_ALU; alu_op = ALU_AND; end
         OP_OR:   begin op_class = CLS_ALU; alu_op = ALU_OR;  end
         OP_ADDI: op_class = CLS_ADDI;
         OP_LDI:  op_class = CLS_LDI;
         OP_LD:   op_class = CLS_LD;
         OP_ST:   op_class = CLS_ST;
         OP_BR:   op_class = CLS_BR;
         OP_JR:   op_class = CLS_JR;
         OP_JAL:  op_class = CLS_JAL;
         OP_IN:   op_class = CLS_IN;
         OP_OUT:  op_class = CLS_OUT;
         OP_MFHI: op_class = CLS_MFHI;
         OP_MFLO: op_class = CLS_MFLO;
         OP_NOP:  op_class = CLS_NOP;
         OP_HALT: op_class = CLS_HALT;
         default: op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer : hardwired Moore control unit for the Mini SRC datapath.
// Fetches (F0..F3, F1 repeated FETCH_WAIT times), then steps T3..T8 by
// instruction class, returning to F0; halt parks in S_HALT until reset.
//   clock  in  rising-edge clock
//   clear  in  asynchronous active-low reset
//   bus    control_sequencer_if.master: IR/CON_FF in, all control strobes out
// ----------------------------------------------------------------------------
module control_sequencer
   import cpu_defs::*;
#(
   parameter int FETCH_WAIT = 1
) (
   input  logic                       clock,
   input  logic                       clear,
   control_sequencer_if.master        bus
);

   state_e     state_q, state_d;
   logic [1:0] wait_q, wait_d;
   class_e     op_class;
   logic [3:0] alu_op;

   opcode_class_decode u_decode (
      .opcode   (bus.IR[31:27]),
      .op_class (op_class),
      .alu_op   (alu_op)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_F0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Outputs are decoded only while clear is high so that asserting reset
   // mid-instruction drops every strobe (notably ram_write) in the same cycle.
   always_comb begin
      state_d            = state_q;
      wait_d             = wait_q;
      bus.incPC          = 1'b0;
      bus.e_PC           = 1'b0;
      bus.e_IR           = 1'b0;
      bus.e_Y            = 1'b0;
      bus.e_Z            = 1'b0;
      bus.e_MDR          = 1'b0;
      bus.e_MAR          = 1'b0;
      bus.e_OutPort      = 1'b0;
      bus.e_RA           = 1'b0;
      bus.e_CON_FF       = 1'b0;
      bus.ram_read       = 1'b0;
      bus.ram_write      = 1'b0;
      bus.MDR_read       = 1'b0;
      bus.ALU_op         = 4'b0000;
      bus.BusDataSelect  = BUS_NONE;
      bus.Gra            = 1'b0;
      bus.Grb            = 1'b0;
      bus.Grc            = 1'b0;
      bus.e_Rin          = 1'b0;
      bus.e_Rout         = 1'b0;
      bus.BAout          = 1'b0;
      bus.imm_sel        = 1'b0;
      bus.run            = 1'b1;
      bus.illegal        = 1'b0;
      if (clear) begin
         case (state_q)
            S_F0: begin
               bus.BusDataSelect = BUS_PC;
               bus.e_MAR         = 1'b1;
               bus.incPC         = 1'b1;
               wait_d            = '0;
               state_d           = S_F1;
            end
            // Memory read latency: stay here FETCH_WAIT cycles in total.
            S_F1: begin
               bus.ram_read = 1'b1;
               if (wait_q == 2'(FETCH_WAIT - 1)) state_d = S_F2;
               else                              wait_d  = wait_q + 2'd1;
            end
            S_F2: begin
               bus.ram_read = 1'b1;
               bus.MDR_read = 1'b1;
               bus.e_MDR    = 1'b1;
               state_d      = S_F3;
            end
            S_F3: begin
               bus.BusDataSelect = BUS_MDR;
               bus.e_IR          = 1'b1;
               state_d           = S_T3;
            end
            S_T3: begin
               state_d = S_F0;
               case (op_class)
                  CLS_ALU, CLS_ADDI, CLS_LDI, CLS_LD, CLS_ST: begin
                     bus.Grb = 1'b1; bus.e_Rout = 1'b1; bus.BusDataSelect = BUS_GP; bus.e_Y = 1'b1;
                     // BAout forces R0 to read as zero for base+offset forms.
                     bus.BAout = (op_class == CLS_LDI || op_class == CLS_LD || op_class == CLS_ST);
                     state_d = S_T4;
                  end
                  CLS_BR: begin
                     bus.Gra = 1'b1; bus.e_Rout = 1'b1; bus.BusDataSelect = BUS_GP; bus.e_CON_FF = 1'b1;
                     state_d = S_T4;
                  end
                  CLS_JR:   begin bus.Gra = 1'b1; bus.e_Rout = 1'b1; bus.BusDataSelect = BUS_GP; bus.e_PC = 1'b1; end
                  CLS_JAL:  begin bus.BusDataSelect = BUS_PC; bus.e_RA = 1'b1; state_d = S_T4; end
                  CLS_IN:   begin bus.BusDataSelect = BUS_INPORT; bus.Gra = 1'b1; bus.e_Rin = 1'b1; end
                  CLS_OUT:  begin bus.Gra = 1'b1; bus.e_Rout = 1'b1; bus.BusDataSelect = BUS_GP; bus.e_OutPort = 1'b1; end
                  CLS_MFHI: begin bus.BusDataSelect = BUS_HI; bus.Gra = 1'b1; bus.e_Rin = 1'b1; end
                  CLS_MFLO: begin bus.BusDataSelect = BUS_LO; bus.Gra = 1'b1; bus.e_Rin = 1'b1; end
                  CLS_HALT: state_d = S_HALT;
                  CLS_ILLEGAL: bus.illegal = 1'b1;
                  default: ;
               endcase
            end
            S_T4: begin
               state_d = S_F0;
               case (op_class)
                  CLS_ALU: begin
                     bus.Grc = 1'b1; bus.e_Rout = 1'b1; bus.BusDataSelect = BUS_GP;
                     bus.ALU_op = alu_op; bus.e_Z = 1'b1;
                     state_d = S_T5;
                  end
                  CLS_ADDI, CLS_LDI, CLS_LD, CLS_ST: begin
                     bus.imm_sel = 1'b1; bus.BusDataSelect = BUS_C; bus.ALU_op = ALU_ADD; bus.e_Z = 1'b1;
                     state_d = S_T5;
                  end
                  CLS_BR:  begin bus.BusDataSelect = BUS_PC; bus.e_Y = 1'b1; state_d = S_T5; end
                  CLS_JAL: begin bus.Gra = 1'b1; bus.e_Rout = 1'b1; bus.BusDataSelect = BUS_GP; bus.e_PC = 1'b1; end
                  default: ;
               endcase
            end
            S_T5: begin
               state_d = S_F0;
               case (op_class)
                  CLS_ALU, CLS_ADDI, CLS_LDI: begin
                     bus.BusDataSelect = BUS_ZLO; bus.Gra = 1'b1; bus.e_Rin = 1'b1;
                  end
                  CLS_LD, CLS_ST: begin bus.BusDataSelect = BUS_ZLO; bus.e_MAR = 1'b1; state_d = S_T6; end
                  CLS_BR: begin
                     bus.imm_sel = 1'b1; bus.BusDataSelect = BUS_C; bus.ALU_op = ALU_ADD; bus.e_Z = 1'b1;
                     state_d = S_T6;
                  end
                  default: ;
               endcase
            end
            S_T6: begin
               state_d = S_F0;
               case (op_class)
                  CLS_LD: begin bus.ram_read = 1'b1; state_d = S_T7; end
                  CLS_ST: begin
                     bus.Gra = 1'b1; bus.e_Rout = 1'b1; bus.BusDataSelect = BUS_GP; bus.e_MDR = 1'b1;
                     state_d = S_T7;
                  end
                  // Branch taken only when the condition flop is set this cycle.
                  CLS_BR: begin bus.BusDataSelect = BUS_ZLO; bus.e_PC = bus.CON_FF; end
                  default: ;
               endcase
            end
            S_T7: begin
               state_d = S_F0;
               case (op_class)
                  CLS_LD: begin
                     bus.ram_read = 1'b1; bus.MDR_read = 1'b1; bus.e_MDR = 1'b1;
                     state_d = S_T8;
                  end
                  CLS_ST: bus.ram_write = 1'b1;
                  default: ;
               endcase
            end
            S_T8: begin
               state_d = S_F0;
               if (op_class == CLS_LD) begin
                  bus.BusDataSelect = BUS_MDR; bus.Gra = 1'b1; bus.e_Rin = 1'b1;
               end
            end
            S_HALT: bus.run = 1'b0;
            default: state_d = S_F0;
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer : self-checking bench for control_sequencer.
// An instruction-level model lists the control word every cycle of each
// instruction must show; a negedge process compares the DUT to that list.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

   localparam int FW = 1;

   localparam int M_INCPC = 1 << 0,  M_EPC   = 1 << 1,  M_EIR   = 1 << 2,  M_EY    = 1 << 3;
   localparam int M_EZ    = 1 << 4,  M_EMDR  = 1 << 5,  M_EMAR  = 1 << 6,  M_EOUT  = 1 << 7;
   localparam int M_ERA   = 1 << 8,  M_ECON  = 1 << 9,  M_RAMRD = 1 << 10, M_RAMWR = 1 << 11;
   localparam int M_MDRRD = 1 << 12, M_GRA   = 1 << 13, M_GRB   = 1 << 14, M_GRC   = 1 << 15;
   localparam int M_ERIN  = 1 << 16, M_EROUT = 1 << 17, M_BAOUT = 1 << 18, M_IMM   = 1 << 19;
   localparam int M_RUN   = 1 << 20, M_ILL   = 1 << 21;

   localparam logic [4:0] B_NONE = 5'b00000, B_GP = 5'b00001, B_HI = 5'b10000, B_LO = 5'b10001;
   localparam logic [4:0] B_ZLO = 5'b10011, B_PC = 5'b10100, B_MDR = 5'b10101;
   localparam logic [4:0] B_IN = 5'b10110, B_C = 5'b11000;
   localparam logic [3:0] A_ADD = 4'b0011;

   typedef struct packed {
      logic [21:0] flags;
      logic [3:0]  alu;
      logic [4:0]  bus;
   } cw_t;

   logic clock;
   logic clear;
   control_sequencer_if sif ();

   control_sequencer #(.FETCH_WAIT(FW)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (sif)
   );

   int   checks = 0;
   int   passes = 0;
   int   cycle_no = 0;
   cw_t  exp_q[$];
   cw_t  mdl_q[$];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic cw_t w(input int f, input logic [3:0] a, input logic [4:0] b);
      cw_t c;
      c.flags = 22'(f | M_RUN);
      c.alu   = a;
      c.bus   = b;
      return c;
   endfunction

   function automatic cw_t dutWord();
      int  f;
      cw_t c;
      f = 0;
      if (sif.incPC)     f |= M_INCPC;
      if (sif.e_PC)      f |= M_EPC;
      if (sif.e_IR)      f |= M_EIR;
      if (sif.e_Y)       f |= M_EY;
      if (sif.e_Z)       f |= M_EZ;
      if (sif.e_MDR)     f |= M_EMDR;
      if (sif.e_MAR)     f |= M_EMAR;
      if (sif.e_OutPort) f |= M_EOUT;
      if (sif.e_RA)      f |= M_ERA;
      if (sif.e_CON_FF)  f |= M_ECON;
      if (sif.ram_read)  f |= M_RAMRD;
      if (sif.ram_write) f |= M_RAMWR;
      if (sif.MDR_read)  f |= M_MDRRD;
      if (sif.Gra)       f |= M_GRA;
      if (sif.Grb)       f |= M_GRB;
      if (sif.Grc)       f |= M_GRC;
      if (sif.e_Rin)     f |= M_ERIN;
      if (sif.e_Rout)    f |= M_EROUT;
      if (sif.BAout)     f |= M_BAOUT;
      if (sif.imm_sel)   f |= M_IMM;
      if (sif.run)       f |= M_RUN;
      if (sif.illegal)   f |= M_ILL;
      c.flags = 22'(f);
      c.alu   = sif.ALU_op;
      c.bus   = sif.BusDataSelect;
      return c;
   endfunction

   // Instruction-level model: fetch words then the execute steps of one opcode.
   task automatic modelInstr(input logic [4:0] op, input logic con);
      int fa;
      mdl_q.delete();
      mdl_q.push_back(w(M_INCPC | M_EMAR, 4'd0, B_PC));
      for (int i = 0; i < FW; i++) mdl_q.push_back(w(M_RAMRD, 4'd0, B_NONE));
      mdl_q.push_back(w(M_RAMRD | M_MDRRD | M_EMDR, 4'd0, B_NONE));
      mdl_q.push_back(w(M_EIR, 4'd0, B_MDR));
      fa = M_GRB | M_EROUT | M_EY;
      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
            mdl_q.push_back(w(fa, 4'd0, B_GP));
            mdl_q.push_back(w(M_GRC | M_EROUT | M_EZ,
                              (op == 5'b00011) ? 4'b0011 : (op == 5'b00100) ? 4'b0100 :
                              (op == 5'b00101) ? 4'b0101 : 4'b0110, B_GP));
            mdl_q.push_back(w(M_GRA | M_ERIN, 4'd0, B_ZLO));
         end
         5'b01100, 5'b01000: begin
            mdl_q.push_back(w(fa | ((op == 5'b01000) ? M_BAOUT : 0), 4'd0, B_GP));
            mdl_q.push_back(w(M_IMM | M_EZ, A_ADD, B_C));
            mdl_q.push_back(w(M_GRA | M_ERIN, 4'd0, B_ZLO));
         end
         5'b00000, 5'b00010: begin
            mdl_q.push_back(w(fa | M_BAOUT, 4'd0, B_GP));
            mdl_q.push_back(w(M_IMM | M_EZ, A_ADD, B_C));
            mdl_q.push_back(w(M_EMAR, 4'd0, B_ZLO));
            if (op == 5'b00000) begin
               mdl_q.push_back(w(M_RAMRD, 4'd0, B_NONE));
               mdl_q.push_back(w(M_RAMRD | M_MDRRD | M_EMDR, 4'd0, B_NONE));
               mdl_q.push_back(w(M_GRA | M_ERIN, 4'd0, B_MDR));
            end else begin
               mdl_q.push_back(w(M_GRA | M_EROUT | M_EMDR, 4'd0, B_GP));
               mdl_q.push_back(w(M_RAMWR, 4'd0, B_NONE));
            end
         end
         5'b10011: begin
            mdl_q.push_back(w(M_GRA | M_EROUT | M_ECON, 4'd0, B_GP));
            mdl_q.push_back(w(M_EY, 4'd0, B_PC));
            mdl_q.push_back(w(M_IMM | M_EZ, A_ADD, B_C));
            mdl_q.push_back(w(con ? M_EPC : 0, 4'd0, B_ZLO));
         end
         5'b10100: mdl_q.push_back(w(M_GRA | M_EROUT | M_EPC, 4'd0, B_GP));
         5'b10101: begin
            mdl_q.push_back(w(M_ERA, 4'd0, B_PC));
            mdl_q.push_back(w(M_GRA | M_EROUT | M_EPC, 4'd0, B_GP));
         end
         5'b10110: mdl_q.push_back(w(M_GRA | M_ERIN, 4'd0, B_IN));
         5'b10111: mdl_q.push_back(w(M_GRA | M_EROUT | M_EOUT, 4'd0, B_GP));
         5'b11000: mdl_q.push_back(w(M_GRA | M_ERIN, 4'd0, B_HI));
         5'b11001: mdl_q.push_back(w(M_GRA | M_ERIN, 4'd0, B_LO));
         5'b11010, 5'b11011: mdl_q.push_back(w(0, 4'd0, B_NONE));
         default: mdl_q.push_back(w(M_ILL, 4'd0, B_NONE));
      endcase
   endtask

   task automatic checkOutput(input string name, input cw_t got, input cw_t exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got flags=%h alu=%h bus=%b, expected flags=%h alu=%h bus=%b",
                    name, got.flags, got.alu, got.bus, exp.flags, exp.alu, exp.bus);
   endtask

   task automatic checkCount(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   // Per-cycle compare against the expected-word list.
   always @(negedge clock) begin
      cw_t e;
      cycle_no++;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checkOutput($sformatf("cycle%0d", cycle_no), dutWord(), e);
      end
   end

   // Waits until every queued word has been compared; returns on a posedge.
   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         @(posedge clock);
         if (exp_q.size() == 0) return;
      end
      checkCount("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic applyStimulus(input logic [31:0] ir, input logic con);
      sif.IR     = ir;
      sif.CON_FF = con;
      modelInstr(ir[31:27], con);
      foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      drain();
      #1;
   endtask

   initial begin
      cw_t halted;
      cw_t rst_word;
      halted   = '0;
      rst_word = w(0, 4'd0, B_NONE);
      clear      = 1'b0;
      sif.IR     = 32'h0;
      sif.CON_FF = 1'b0;

      // Hand-computed literals pinning the model.
      modelInstr(5'b11010, 1'b0); checkCount("len_nop", mdl_q.size(), 5);
      modelInstr(5'b10100, 1'b0); checkCount("len_jr", mdl_q.size(), 5);
      modelInstr(5'b10101, 1'b0); checkCount("len_jal", mdl_q.size(), 6);
      modelInstr(5'b00011, 1'b0); checkCount("len_alu", mdl_q.size(), 7);
      modelInstr(5'b10011, 1'b0); checkCount("len_br", mdl_q.size(), 8);
      modelInstr(5'b00010, 1'b0); checkCount("len_st", mdl_q.size(), 9);
      checkOutput("st_t7_pin", mdl_q[8], cw_t'{22'(M_RAMWR | M_RUN), 4'd0, 5'b00000});
      modelInstr(5'b00000, 1'b0); checkCount("len_ld", mdl_q.size(), 10);
      checkOutput("ld_t8_pin", mdl_q[9], cw_t'{22'(M_GRA | M_ERIN | M_RUN), 4'd0, 5'b10101});
      modelInstr(5'b01000, 1'b0);
      checkOutput("ldi_t4_pin", mdl_q[5], cw_t'{22'(M_IMM | M_EZ | M_RUN), 4'b0011, 5'b11000});
      modelInstr(5'b10011, 1'b1);
      checkOutput("br_t6_pin", mdl_q[7], cw_t'{22'(M_EPC | M_RUN), 4'd0, 5'b10011});

      repeat (2) @(posedge clock);
      #2;
      checkOutput("reset_outputs", dutWord(), rst_word);
      clear = 1'b1;

      applyStimulus(32'h42000078, 1'b0);   // ldi R4,0x78
      applyStimulus(32'h18000000, 1'b1);   // add (CON_FF ignored)
      applyStimulus(32'h20000000, 1'b0);   // sub
      applyStimulus(32'h28000000, 1'b0);   // and
      applyStimulus(32'h30000000, 1'b0);   // or
      applyStimulus(32'h60000000, 1'b0);   // addi
      applyStimulus(32'h98000000, 1'b0);   // br not taken
      applyStimulus(32'h98000000, 1'b1);   // br taken
      applyStimulus(32'hA0000000, 1'b0);   // jr
      applyStimulus(32'hA8000000, 1'b0);   // jal
      applyStimulus(32'hB0000000, 1'b0);   // in
      applyStimulus(32'hB8000000, 1'b0);   // out
      applyStimulus(32'hC0000000, 1'b0);   // mfhi
      applyStimulus(32'hC8000000, 1'b0);   // mflo
      applyStimulus(32'hD0000000, 1'b0);   // nop
      applyStimulus(32'h10000000, 1'b0);   // st
      applyStimulus(32'h00000000, 1'b0);   // ld
      applyStimulus(32'hF8000000, 1'b0);   // undefined opcode
      applyStimulus(32'hD0000000, 1'b0);   // nop after illegal starts at F0

      // Reset asserted during ld T6.
      sif.IR = 32'h00000000;
      modelInstr(5'b00000, 1'b0);
      for (int i = 0; i < 7; i++) exp_q.push_back(mdl_q[i]);
      drain();
      #2;
      checkOutput("ld_t6_before_abort", dutWord(), w(M_RAMRD, 4'd0, B_NONE));
      clear = 1'b0;
      #1;
      checkOutput("async_abort_outputs", dutWord(), rst_word);
      @(posedge clock);
      #2;
      clear = 1'b1;
      applyStimulus(32'hD0000000, 1'b0);

      // Halt: parked with run low for 20 cycles, then reset recovers.
      sif.IR = 32'hD8000000;
      modelInstr(5'b11011, 1'b0);
      foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      for (int i = 0; i < 20; i++) exp_q.push_back(halted);
      drain();
      #2;
      checkOutput("halted_still", dutWord(), halted);
      clear = 1'b0;
      #1;
      checkOutput("halt_reset_outputs", dutWord(), rst_word);
      @(posedge clock);
      #2;
      clear = 1'b1;
      applyStimulus(32'h42000078, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the Mini SRC datapath.
- Generates every datapath control strobe that the hand-written bench FSMs currently drive. It fetches instructions, decodes IR, and steps through T0..T8 per instruction class.
- Sits beside datapath at the top level, reads IR and CON_FF back from it, and runs until halt.

Parameters:
- FETCH_WAIT, 1, number of extra ram_read cycles before MDR capture (1..3).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents from datapath.
- CON_FF  in  1  branch condition flip-flop output.
- incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_OutPort, e_RA, e_CON_FF  out  1 each  register load/strobe enables.
- ram_read, ram_write, MDR_read  out  1 each  memory controls.
- ALU_op  out  4  ALU operation.
- BusDataSelect  out  5  bus source select.
- Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel  out  1 each  select/encode controls.
- run  out  1  high while executing, low once halted.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (clear=0, async): state=F0, all outputs 0 except run=1. Reset mid-instruction aborts with no partial write; ram_write deasserts immediately.
- Outputs are a combinational decode of (state, IR[31:27]) and are registered nowhere else. In every state, any output not listed is 0; BusDataSelect defaults to BUS_NONE.
- Opcodes (IR[31:27]): ld 00000, st 00010, add 00011, sub 00100, and 00101, or 00110, ldi 01000, addi 01100, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.
- Fetch:
  - F0: BUS_PC, e_MAR, incPC.
  - F1 (repeated FETCH_WAIT times): ram_read.
  - F2: ram_read, MDR_read, e_MDR.
  - F3: BUS_MDR, e_IR.
  - Then T3. IR is only valid from T3 onward.
- Execute, one state per step (BUS_GP means Rout of the selected register):
  - add/sub/and/or:
    - T3: Grb, e_Rout, BUS_GP, e_Y.
    - T4: Grc, e_Rout, BUS_GP, ALU_op=opcode map, e_Z.
    - T5: BUS_ZLO, Gra, e_Rin.
  - addi:
    - T3: Grb, e_Rout, BUS_GP, e_Y.
    - T4: imm_sel, BUS_C, ALU_ADD, e_Z.
    - T5: BUS_ZLO, Gra, e_Rin.
  - ldi: as addi, plus BAout in T3 (R0 field reads 0).
  - ld:
    - T3..T4: as ldi.
    - T5: BUS_ZLO, e_MAR.
    - T6: ram_read.
    - T7: ram_read, MDR_read, e_MDR.
    - T8: BUS_MDR, Gra, e_Rin.
  - st:
    - T3..T5: as ld.
    - T6: Gra, e_Rout, BUS_GP, e_MDR (MDR_read=0).
    - T7: ram_write.
  - br:
    - T3: Gra, e_Rout, BUS_GP, e_CON_FF.
    - T4: BUS_PC, e_Y.
    - T5: imm_sel, BUS_C, ALU_ADD, e_Z.
    - T6: BUS_ZLO, e_PC, with e_PC asserted only if CON_FF=1.
  - jr: T3: Gra, e_Rout, BUS_GP, e_PC.
  - jal:
    - T3: BUS_PC, e_RA.
    - T4: Gra, e_Rout, BUS_GP, e_PC.
  - in: T3: BUS_INPORT, Gra, e_Rin.
  - out: T3: Gra, e_Rout, BUS_GP, e_OutPort.
  - mfhi / mflo: T3: BUS_HI or BUS_LO, Gra, e_Rin.
  - nop: no execute steps.
  - halt: enter HALT; run=0 and all strobes 0 until reset.
  - Undefined opcode: illegal=1 during T3; otherwise behaves as nop.
- After the last step of an instruction, the next state is F0.
- Latency in cycles including fetch with FETCH_WAIT=1: nop 5, jr 5, jal 6, ALU 7, br 8, st 9, ld 10.
- CON_FF is sampled combinationally in br T6 only; a change in other states has no effect.
- At most one bus source per cycle: e_Rout never coincides with a non-GP BusDataSelect code. ram_read and ram_write are never both high.

Decomposition:
- Shared package cpu_defs holds:
  - opcode localparams;
  - ALU_op codes (ALU_ADD=0011, ALU_SUB=0100, ALU_AND=0101, ALU_OR=0110);
  - BusDataSelect codes (BUS_NONE=00000, BUS_GP=00001, BUS_HI=10000, BUS_LO=10001, BUS_ZLO=10011, BUS_PC=10100, BUS_MDR=10101, BUS_INPORT=10110, BUS_C=11000);
  - state encodings.
- One sub-module, opcode_class_decode: combinational, IR[31:27] to instruction class plus ALU_op.

Test Plan:
- Reset then IR=0x42000078 (ldi R4,0x78): F0 shows BUS_PC+e_MAR+incPC; T3 shows Grb+BAout+e_Y; T4 shows imm_sel, ALU_op=0011, e_Z; T5 shows BUS_ZLO+Gra+e_Rin; back to F0 after 7 cycles.
- br (opcode 10011) with CON_FF=0, then CON_FF=1: T6 has BusDataSelect=10011 in both cases; e_PC=0 in the first case, 1 in the second.
- st then ld: st T7 has ram_write=1 and ram_read=0; ld T7 has MDR_read=1 and e_MDR=1; ld T8 has BUS_MDR+e_Rin. Totals are 9 and 10 cycles.
- Opcode 11111: illegal pulses exactly one cycle; next state is F0; no e_Rin or ram_write.
- halt: run falls after T3 and stays 0 for 20 cycles with all strobes 0; clear=0 restores F0 and run=1.
- Assert clear=0 during ld T6: outputs go to 0 within the same cycle, asynchronously; after release, the first state is F0.
